// File: rtl/adc_sar_logic_if.sv
// Signal bundle between the SAR sequencer and its comparator / DAC decoder neighbours.
// The master modport is the sequencer side; slave is the analog-front-end side.
interface adc_sar_logic_if #(
  parameter int N_BITS = 12
);
  logic              start_i;
  logic              comp_i;
  logic              sample_o;
  logic              comp_latch_o;
  logic [N_BITS-1:0] data_o;
  logic [N_BITS-1:0] result_o;
  logic              result_valid_o;
  logic              busy_o;

  modport master (
    input  start_i, comp_i,
    output sample_o, comp_latch_o, data_o, result_o, result_valid_o, busy_o
  );

  modport slave (
    output start_i, comp_i,
    input  sample_o, comp_latch_o, data_o, result_o, result_valid_o, busy_o
  );
endinterface

// File: rtl/adc_sar_logic.sv
// SAR ADC control: sample, then a bit-serial binary search driving the DAC decoder code.
// Define ADC_SAR_CONTINUOUS_EN to restart conversions back-to-back while start_i stays high.
module adc_sar_logic #(
  parameter int N_BITS        = 12,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  adc_sar_logic_if.master bus
);

  localparam int IDX_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0]  IDX_TOP     = IDX_W'(N_BITS - 1);
  localparam logic [N_BITS-1:0] MSB_CODE    = N_BITS'(1) << (N_BITS - 1);
  localparam bit                SKIP_SETTLE = (SETTLE_CYCLES == 0);

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    SETTLE,
    STROBE,
    DECIDE,
    DONE
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [IDX_W-1:0]  idx, idx_next;
  logic              sample_q, sample_next;
  logic              latch_q, latch_next;
  logic [N_BITS-1:0] data_q, data_next;
  logic [N_BITS-1:0] result_q, result_next;
  logic              valid_q, valid_next;
  logic              busy_q, busy_next;

  // Every output is computed one step ahead so it is registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= IDX_TOP;
      sample_q <= 1'b0;
      latch_q  <= 1'b0;
      data_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      idx      <= idx_next;
      sample_q <= sample_next;
      latch_q  <= latch_next;
      data_q   <= data_next;
      result_q <= result_next;
      valid_q  <= valid_next;
      busy_q   <= busy_next;
    end
  end

  // Next-state and next-output logic; the comparator strobe and valid are single-cycle pulses.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    idx_next    = idx;
    sample_next = sample_q;
    latch_next  = 1'b0;
    data_next   = data_q;
    result_next = result_q;
    valid_next  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start_i) begin
          state_next  = SAMPLE;
          cnt_next    = SAMPLE_LOAD;
          sample_next = 1'b1;
          data_next   = MSB_CODE;
        end
      end

      SAMPLE: begin
        if (cnt == '0) begin
          sample_next = 1'b0;
          if (SKIP_SETTLE) begin
            state_next = STROBE;
            latch_next = 1'b1;
          end else begin
            state_next = SETTLE;
            cnt_next   = SETTLE_LOAD;
          end
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end

      SETTLE: begin
        if (cnt == '0) begin
          state_next = STROBE;
          latch_next = 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end

      STROBE: begin
        state_next = DECIDE;
      end

      // Comparator is only trusted here, one cycle after the strobe.
      DECIDE: begin
        if (!bus.comp_i) begin
          data_next[idx] = 1'b0;
        end
        if (idx != '0) begin
          data_next[idx - 1'b1] = 1'b1;
          idx_next              = idx - 1'b1;
          if (SKIP_SETTLE) begin
            state_next = STROBE;
            latch_next = 1'b1;
          end else begin
            state_next = SETTLE;
            cnt_next   = SETTLE_LOAD;
          end
        end else begin
          state_next  = DONE;
          result_next = data_next;
          valid_next  = 1'b1;
        end
      end

      DONE: begin
        idx_next = IDX_TOP;
`ifdef ADC_SAR_CONTINUOUS_EN
        if (bus.start_i) begin
          state_next  = SAMPLE;
          cnt_next    = SAMPLE_LOAD;
          sample_next = 1'b1;
          data_next   = MSB_CODE;
        end else begin
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign bus.sample_o       = sample_q;
  assign bus.comp_latch_o   = latch_q;
  assign bus.data_o         = data_q;
  assign bus.result_o       = result_q;
  assign bus.result_valid_o = valid_q;
  assign bus.busy_o         = busy_q;

endmodule

// File: tb/tb_adc_sar_logic.sv
// Directed bench for adc_sar_logic: a default-timing DUT and a fast DUT (SETTLE=0, SAMPLE=1)
// share one ideal comparator model, comp_i = (vin >= data_o).
module tb_adc_sar_logic;

  logic        clk;
  logic        rst;
  logic        start1;
  logic        start2;
  logic [11:0] vin;

  int n_checks;
  int n_fail;

  adc_sar_logic_if #(.N_BITS(12)) bus1 ();
  adc_sar_logic_if #(.N_BITS(12)) bus2 ();

  assign bus1.start_i = start1;
  assign bus1.comp_i  = (vin >= bus1.data_o);
  assign bus2.start_i = start2;
  assign bus2.comp_i  = (vin >= bus2.data_o);

  adc_sar_logic #(.N_BITS(12), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  adc_sar_logic #(.N_BITS(12), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(0)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [11:0] vin;
    logic [11:0] exp_result;
    int          exp_latency;
    int          exp_strobes;
    int          exp_samples;
    int          exp_busy;
  } vec_t;

  vec_t vecs [6];

  int          obs_latency;
  int          obs_strobes;
  int          obs_samples;
  int          obs_valids;
  int          obs_busy;
  logic [11:0] obs_result;
  logic [11:0] data_trace [0:127];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One start pulse, then observe per-cycle until two cycles past the valid pulse (bounded).
  task automatic apply_stimulus(input logic sel_i, input logic [11:0] vin_i);
    vin = vin_i;
    obs_latency = 0;
    obs_strobes = 0;
    obs_samples = 0;
    obs_valids  = 0;
    obs_busy    = 0;
    obs_result  = '0;
    @(negedge clk);
    if (sel_i) start2 = 1'b1;
    else       start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
    for (int c = 1; c < 120; c++) begin
      @(negedge clk);
      data_trace[c] = sel_i ? bus2.data_o : bus1.data_o;
      if (sel_i ? bus2.sample_o : bus1.sample_o)         obs_samples++;
      if (sel_i ? bus2.comp_latch_o : bus1.comp_latch_o) obs_strobes++;
      if (sel_i ? bus2.busy_o : bus1.busy_o)             obs_busy++;
      if (sel_i ? bus2.result_valid_o : bus1.result_valid_o) begin
        obs_valids++;
        if (obs_latency == 0) begin
          obs_latency = c;
          obs_result  = sel_i ? bus2.result_o : bus1.result_o;
        end
      end
      if (obs_latency != 0 && c >= obs_latency + 2) break;
    end
  endtask

  initial begin
    int first_v;
    int second_v;
    logic [11:0] r1;
    logic [11:0] r2;

    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start1   = 1'b0;
    start2   = 1'b0;
    vin      = '0;

    vecs[0] = '{1'b0, 12'hAAA, 12'hAAA, 41, 12, 4, 41};
    vecs[1] = '{1'b0, 12'h000, 12'h000, 41, 12, 4, 41};
    vecs[2] = '{1'b0, 12'hFFF, 12'hFFF, 41, 12, 4, 41};
    vecs[3] = '{1'b0, 12'h123, 12'h123, 41, 12, 4, 41};
    vecs[4] = '{1'b1, 12'h7FF, 12'h7FF, 26, 12, 1, 26};
    vecs[5] = '{1'b1, 12'h800, 12'h800, 26, 12, 1, 26};

    #3;
    check_output("reset sample_o",       bus1.sample_o, 0);
    check_output("reset comp_latch_o",   bus1.comp_latch_o, 0);
    check_output("reset data_o",         bus1.data_o, 0);
    check_output("reset result_o",       bus1.result_o, 0);
    check_output("reset result_valid_o", bus1.result_valid_o, 0);
    check_output("reset busy_o",         bus1.busy_o, 0);
    check_output("reset fast data_o",    bus2.data_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] table-driven conversions");
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i].sel, vecs[i].vin);
      check_output($sformatf("v%0d result", i),  obs_result,  vecs[i].exp_result);
      check_output($sformatf("v%0d latency", i), obs_latency, vecs[i].exp_latency);
      check_output($sformatf("v%0d strobes", i), obs_strobes, vecs[i].exp_strobes);
      check_output($sformatf("v%0d samples", i), obs_samples, vecs[i].exp_samples);
      check_output($sformatf("v%0d valids", i),  obs_valids,  1);
      check_output($sformatf("v%0d busy", i),    obs_busy,    vecs[i].exp_busy);
      if (vecs[i].vin == 12'hAAA && !vecs[i].sel) begin
        check_output("AAA data c1",  data_trace[1],  12'h800);
        check_output("AAA data c7",  data_trace[7],  12'h800);
        check_output("AAA data c8",  data_trace[8],  12'hC00);
        check_output("AAA data c11", data_trace[11], 12'hA00);
        check_output("AAA data c41", data_trace[41], 12'hAAA);
      end
    end

    $display("[TB] reset during bit 5");
    vin = 12'hFFF;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    for (int c = 1; c <= 23; c++) @(negedge clk);
    check_output("bit5 data_o", bus1.data_o, 12'hFE0);
    check_output("bit5 busy_o", bus1.busy_o, 1);
    #2;
    rst = 1'b1;
    #1;
    check_output("abort sample_o",       bus1.sample_o, 0);
    check_output("abort comp_latch_o",   bus1.comp_latch_o, 0);
    check_output("abort data_o",         bus1.data_o, 0);
    check_output("abort result_o",       bus1.result_o, 0);
    check_output("abort result_valid_o", bus1.result_valid_o, 0);
    check_output("abort busy_o",         bus1.busy_o, 0);
    @(negedge clk);
    rst = 1'b0;
    obs_valids = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus1.result_valid_o) obs_valids++;
    end
    check_output("abort no valid", obs_valids, 0);
    apply_stimulus(1'b0, 12'h123);
    check_output("post-abort result",  obs_result, 12'h123);
    check_output("post-abort latency", obs_latency, 41);

    $display("[TB] start held high, back-to-back");
    vin = 12'hAAA;
    first_v  = 0;
    second_v = 0;
    r1 = '0;
    r2 = '0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    for (int c = 1; c < 150; c++) begin
      @(negedge clk);
      if (bus1.result_valid_o) begin
        if (first_v == 0) begin
          first_v = c;
          r1 = bus1.result_o;
        end else begin
          second_v = c;
          r2 = bus1.result_o;
        end
      end
      if (second_v != 0) break;
    end
    start1 = 1'b0;
    check_output("b2b first latency",  first_v,  41);
    check_output("b2b second latency", second_v, 83);
    check_output("b2b first result",   r1, 12'hAAA);
    check_output("b2b second result",  r2, 12'hAAA);
    repeat (3) @(negedge clk);
    check_output("b2b idle busy_o", bus1.busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_sar_logic.md
Name: adc_sar_logic

Overview:
Successive-approximation control stage for the SAR ADC. It sits directly upstream of the capacitor-array row/column decoder: it runs sample, then a binary search over N_BITS, and drives the trial code into the decoder's 12-bit data input each bit cycle. It strobes the comparator and uses the comparator decision to keep or clear each trial bit. It presents the final code with a one-cycle valid pulse.

Parameters:
N_BITS, 12, conversion width; it must equal the decoder data_in width.
SAMPLE_CYCLES, 4, number of cycles sample_o is held high (min 1).
SETTLE_CYCLES, 1, DAC settle cycles before each comparator strobe (min 0).

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous reset, active-high.
start_i  input  1  conversion request, level-sampled.
comp_i  input  1  comparator decision; 1 = Vin >= DAC, so keep the bit.
sample_o  output  1  sampling switch enable.
comp_latch_o  output  1  comparator strobe.
data_o  output  N_BITS  trial code to the decoder data_in.
result_o  output  N_BITS  last completed conversion.
result_valid_o  output  1  one-cycle pulse, result_o is new.
busy_o  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; sample_o=0; comp_latch_o=0; data_o=0; result_o=0; result_valid_o=0; busy_o=0; bit index=N_BITS-1.
- All outputs are registered. comp_i is sampled only on the clock edge that ends the DECIDE state.
- IDLE: if start_i=1 at an edge, go to SAMPLE. data_o and result_o hold their values.
- SAMPLE (SAMPLE_CYCLES cycles): sample_o=1; data_o=1<<(N_BITS-1), i.e. 12'h800. On exit, go to SETTLE, or to STROBE if SETTLE_CYCLES=0.
- SETTLE (SETTLE_CYCLES cycles): outputs hold; the DAC settles.
- STROBE (1 cycle): comp_latch_o=1.
- DECIDE (1 cycle): comp_latch_o=0. At the ending edge:
  - If comp_i=0, clear data_o[idx].
  - If idx>0, set data_o[idx-1], decrement idx, and go to SETTLE (or STROBE if SETTLE_CYCLES=0).
  - If idx=0, go to DONE.
- DONE (1 cycle): result_o=data_o; result_valid_o=1; then go to IDLE and reset idx to N_BITS-1.
- Latency: result_valid_o is high in cycle SAMPLE_CYCLES + N_BITS*(SETTLE_CYCLES+2) + 1 after the edge that samples start_i. With defaults this is cycle 41.
- Back-to-back: start_i high in the DONE cycle is ignored. start_i sampled in IDLE on the following edge starts the next conversion, giving a 42-cycle minimum period with defaults.
- start_i while busy_o=1 is ignored, with no restart and no queueing.
- comp_i toggling outside DECIDE has no effect.
- Reset mid-conversion aborts immediately. No result_valid_o is produced and result_o returns to 0.
- Bit 0 is always evaluated. Boundary codes 0 and 2^N_BITS-1 are both reachable.

Optional Feature:
Macro ADC_SAR_CONTINUOUS_EN.
- With the macro defined: DONE goes directly to SAMPLE, not IDLE, while start_i=1, so conversions repeat continuously. busy_o stays 1, and the period is SAMPLE_CYCLES + N_BITS*(SETTLE_CYCLES+2) + 1 (41 with defaults). If start_i=0 in DONE, the next state is IDLE.
- Without the macro: DONE always goes to IDLE, as described above.

Test Plan:
- Bench comparator model comp_i=(vin>=data_o), vin=12'hAAA, single start pulse -> sample_o high for 4 cycles; data_o sequence 800, C00→800 (after clear), A00, ...; result_o=12'hAAA; result_valid_o is a single pulse in cycle 41.
- vin=0 then vin=4095 -> result_o=12'h000, then 12'hFFF; comp_latch_o pulses exactly 12 times per conversion.
- start_i held high continuously (macro off) -> a new conversion every 42 cycles; start_i during busy_o does not alter data_o or the timing.
- rst asserted during bit 5 of a conversion -> all outputs 0 immediately; no valid pulse; a new start afterwards converts vin=12'h123 correctly.
- SETTLE_CYCLES=0, SAMPLE_CYCLES=1 -> result_valid_o at cycle 26; vin=12'h7FF gives result 12'h7FF.
- ADC_SAR_CONTINUOUS_EN defined, start_i high, vin stepped 100→3000 mid-run -> results 100, then 3000 for conversions whose sample phase follows the step; valid pulses 41 cycles apart; busy_o never drops.
